// File: rtl/piso_sched.sv
// Two-source round-robin scheduler driving a DW-bit parallel-in/serial-out shifter.
// Each word is sent as one load cycle and DW shift cycles, optionally followed by GAP idle cycles.
module piso_sched #(
    parameter int DW  = 4,
    parameter int GAP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          sh_sel,
    output logic [DW-1:0] sh_data,
    output logic          bit_vld,
    output logic          bit_src,
    output logic          frame_last,
    output logic          busy
);
    localparam int            CW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
    localparam logic [3:0]    GAP_LOAD = 4'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic          HAS_GAP  = (GAP > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [3:0]    gap_r;
    logic          cur_src_r;
    logic          last_src_r;
    logic          pick1_s;
    logic          hs_s;
    logic [DW-1:0] hs_data_s;

    // Round-robin pick: on a tie the source not served last wins
    always_comb begin
        pick1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            pick1_s = ~last_src_r;
        end else begin
            pick1_s = req1_valid;
        end
        req0_ready = (state_r == ST_IDLE) && rst && req0_valid && !pick1_s;
        req1_ready = (state_r == ST_IDLE) && rst && req1_valid && pick1_s;
        hs_s       = req0_ready || req1_ready;
        hs_data_s  = pick1_s ? req1_data : req0_data;
    end

    // Sequencer, shifter drive and strobes delayed to line up with the shifter's registered outbit
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            gap_r      <= 4'd0;
            cur_src_r  <= 1'b0;
            last_src_r <= 1'b1;
            sh_sel     <= 1'b0;
            sh_data    <= '0;
            bit_vld    <= 1'b0;
            bit_src    <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
        end else begin
            bit_vld    <= (state_r == ST_SHIFT);
            bit_src    <= cur_src_r;
            frame_last <= (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);
            case (state_r)
                ST_IDLE: begin
                    sh_sel <= 1'b0;
                    if (hs_s) begin
                        sh_data    <= hs_data_s;
                        cur_src_r  <= pick1_s;
                        last_src_r <= pick1_s;
                        cnt_r      <= '0;
                        state_r    <= ST_LOAD;
                        busy       <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_SHIFT;
                    sh_sel  <= 1'b1;
                    busy    <= 1'b1;
                end
                ST_SHIFT: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        sh_sel <= 1'b0;
                        if (HAS_GAP) begin
                            state_r <= ST_GAP;
                            gap_r   <= GAP_LOAD;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                        sh_sel  <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_GAP: begin
                    sh_sel <= 1'b0;
                    if (gap_r == 4'd0) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        gap_r <= gap_r - 4'd1;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    sh_sel  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piso_sched.sv
// Bench for piso_sched: instance 0 with GAP=0, instance 1 with GAP=3, each feeding a modelled shifter;
// a timeline model predicts every output per cycle.
module tb_piso_sched;
    localparam int DW = 4;
    localparam int N  = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_v [2][2];
    logic [3:0] req_d [2][2];
    logic       req_r [2][2];
    logic       sel [2], vld [2], src [2], lst [2], bsy [2];
    logic [3:0] shd [2];
    logic [3:0] shq [2];
    logic       obit [2];

    int nvec = 0, nmis = 0, cyc = 0;
    bit running = 0, rnd = 0;

    bit e_vld [2][N], e_bit [2][N], e_src [2][N], e_lst [2][N], e_sel [2][N], e_bsy [2][N];
    int nxt_free [2];
    bit m_last [2];
    logic [3:0] m_data [2];
    int hcyc [2][512];
    bit hsrc [2][512];
    int hn [2];
    logic [31:0] bitlog [2];

    bit hs [2][2];
    int wl [2][2][64];
    int wh [2][2], wt [2][2];

    piso_sched #(.DW(4), .GAP(0)) dut0 (
        .clk(clk), .rst(rst),
        .req0_valid(req_v[0][0]), .req0_data(req_d[0][0]), .req0_ready(req_r[0][0]),
        .req1_valid(req_v[0][1]), .req1_data(req_d[0][1]), .req1_ready(req_r[0][1]),
        .sh_sel(sel[0]), .sh_data(shd[0]), .bit_vld(vld[0]), .bit_src(src[0]),
        .frame_last(lst[0]), .busy(bsy[0])
    );

    piso_sched #(.DW(4), .GAP(3)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(req_v[1][0]), .req0_data(req_d[1][0]), .req0_ready(req_r[1][0]),
        .req1_valid(req_v[1][1]), .req1_data(req_d[1][1]), .req1_ready(req_r[1][1]),
        .sh_sel(sel[1]), .sh_data(shd[1]), .bit_vld(vld[1]), .bit_src(src[1]),
        .frame_last(lst[1]), .busy(bsy[1])
    );

    // Shifter being sequenced: active-high reset, load on sel=0, shift LSB out on sel=1
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst) begin
                shq[u]  <= 4'd0;
                obit[u] <= 1'b0;
            end else if (sel[u]) begin
                obit[u] <= shq[u][0];
                shq[u]  <= {1'b0, shq[u][3:1]};
            end else begin
                shq[u] <= shd[u];
            end
        end
    end

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s (dut%0d, cycle %0d): got %0h, expected %0h", nm, u, cyc, act, exp);
        end
    endtask

    // Timeline model: a handshake at cycle T schedules LOAD, DW shift cycles, bits and busy span
    always @(negedge clk) begin
        bit g1, er0, er1;
        int gp;
        if (running) begin
            for (int u = 0; u < 2; u++) begin
                gp = (u == 0) ? 0 : 3;
                chk("bit_vld", u, vld[u], e_vld[u][cyc]);
                chk("frame_last", u, lst[u], e_lst[u][cyc]);
                chk("sh_sel", u, sel[u], e_sel[u][cyc]);
                chk("busy", u, bsy[u], e_bsy[u][cyc]);
                chk("sh_data", u, shd[u], m_data[u]);
                if (e_vld[u][cyc]) begin
                    chk("outbit", u, obit[u], e_bit[u][cyc]);
                    chk("bit_src", u, src[u], e_src[u][cyc]);
                    bitlog[u] = {bitlog[u][30:0], obit[u]};
                end
                g1  = (req_v[u][0] && req_v[u][1]) ? !m_last[u] : req_v[u][1];
                er0 = rst && (cyc >= nxt_free[u]) && req_v[u][0] && !g1;
                er1 = rst && (cyc >= nxt_free[u]) && req_v[u][1] && g1;
                chk("req0_ready", u, req_r[u][0], er0);
                chk("req1_ready", u, req_r[u][1], er1);
                if (!rst) begin
                    for (int c = cyc + 1; c < cyc + 32 && c < N; c++) begin
                        e_vld[u][c] = 0; e_bit[u][c] = 0; e_src[u][c] = 0;
                        e_lst[u][c] = 0; e_sel[u][c] = 0; e_bsy[u][c] = 0;
                    end
                    m_last[u]   = 1;
                    nxt_free[u] = cyc + 1;
                    m_data[u]   = 4'd0;
                end else if (er0 || er1) begin
                    m_data[u] = er1 ? req_d[u][1] : req_d[u][0];
                    m_last[u] = er1;
                    if (hn[u] < 512) begin
                        hcyc[u][hn[u]] = cyc;
                        hsrc[u][hn[u]] = er1;
                        hn[u]++;
                    end
                    for (int k = 0; k < DW; k++) begin
                        e_vld[u][cyc+3+k] = 1;
                        e_bit[u][cyc+3+k] = m_data[u][k];
                        e_src[u][cyc+3+k] = er1;
                        e_lst[u][cyc+3+k] = (k == DW - 1);
                    end
                    for (int c = cyc + 2; c <= cyc + DW + 1; c++) e_sel[u][c] = 1;
                    for (int c = cyc + 1; c <= cyc + DW + 1 + gp; c++) e_bsy[u][c] = 1;
                    nxt_free[u] = cyc + DW + 2 + gp;
                end
            end
            cyc++;
        end
    end

    task automatic feed();
        for (int u = 0; u < 2; u++) begin
            for (int r = 0; r < 2; r++) begin
                if (wh[u][r] < wt[u][r]) begin
                    req_v[u][r] = 1'b1;
                    req_d[u][r] = 4'(wl[u][r][wh[u][r] % 64]);
                end else begin
                    req_v[u][r] = 1'b0;
                end
            end
        end
    endtask

    task automatic push(input int u, input int r, input int w);
        wl[u][r][wt[u][r] % 64] = w;
        wt[u][r]++;
    endtask

    task automatic tick();
        @(negedge clk);
        for (int u = 0; u < 2; u++)
            for (int r = 0; r < 2; r++)
                hs[u][r] = req_v[u][r] && req_r[u][r];
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            for (int r = 0; r < 2; r++) begin
                if (hs[u][r]) wh[u][r]++;
                else if (rnd && req_v[u][r] && $urandom_range(0, 15) == 0) wh[u][r]++;
            end
        end
        feed();
    endtask

    task automatic wait_hs(input int u, input int r);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (hs[u][r]) ok = 1;
        end
        chk("handshake_timeout", u, ok, 1);
    endtask

    initial begin
        int nh;
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            m_last[u] = 1; m_data[u] = 4'd0; bitlog[u] = 32'd0;
            for (int r = 0; r < 2; r++) begin
                req_v[u][r] = 1'b0; req_d[u][r] = 4'd0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        running = 1;
        tick();
        rst = 1'b1;

        // single word from requester 0
        for (int u = 0; u < 2; u++) push(u, 0, 4'b1011);
        feed();
        wait_hs(0, 0);
        repeat (10) tick();
        chk("single_bits", 0, bitlog[0][3:0], 4'b1101);
        chk("single_src", 0, hsrc[0][0], 0);

        // tie after reset: requester 0 first
        rst = 1'b0; repeat (2) tick(); rst = 1'b1;
        for (int u = 0; u < 2; u++) begin push(u, 0, 4'h5); push(u, 1, 4'hA); end
        feed();
        repeat (22) tick();
        for (int u = 0; u < 2; u++) begin
            chk("tie_first_src", u, hsrc[u][1], 0);
            chk("tie_second_src", u, hsrc[u][2], 1);
            chk("tie_spacing", u, hcyc[u][2] - hcyc[u][1], (u == 0) ? 6 : 9);
            chk("tie_bits", u, bitlog[u][7:0], 8'hA5);
        end

        // back-to-back stream from requester 1
        for (int u = 0; u < 2; u++) begin push(u, 1, 1); push(u, 1, 2); push(u, 1, 3); end
        feed();
        repeat (35) tick();
        for (int u = 0; u < 2; u++) begin
            chk("stream_spacing_a", u, hcyc[u][4] - hcyc[u][3], (u == 0) ? 6 : 9);
            chk("stream_spacing_b", u, hcyc[u][5] - hcyc[u][4], (u == 0) ? 6 : 9);
            chk("stream_bits", u, bitlog[u][11:0], 12'h84C);
        end

        // reset in the second shift cycle
        for (int u = 0; u < 2; u++) push(u, 0, 4'hF);
        feed();
        wait_hs(0, 0);
        tick(); tick();
        rst = 1'b0; tick(); rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", u, bsy[u], 0);
            chk("rst_sh_sel", u, sel[u], 0);
            chk("rst_sh_data", u, shd[u], 0);
            chk("rst_bit_vld", u, vld[u], 0);
        end
        repeat (6) tick();
        for (int u = 0; u < 2; u++) begin push(u, 0, 4'h3); push(u, 1, 4'hC); end
        feed();
        repeat (22) tick();
        for (int u = 0; u < 2; u++) chk("post_rst_tie", u, hsrc[u][hn[u]-2], 0);

        // requester 1 valid pulsed during shift, then withdrawn
        for (int u = 0; u < 2; u++) push(u, 0, 4'h6);
        feed();
        wait_hs(0, 0);
        tick(); tick();
        nh = hn[0];
        for (int u = 0; u < 2; u++) begin req_v[u][1] = 1'b1; req_d[u][1] = 4'h9; end
        tick();
        repeat (12) tick();
        chk("withdrawn_no_hs", 0, hn[0], nh);
        for (int u = 0; u < 2; u++) begin push(u, 0, 4'h1); push(u, 1, 4'h2); end
        feed();
        repeat (22) tick();
        for (int u = 0; u < 2; u++) chk("withdrawn_tie", u, hsrc[u][hn[u]-2], 1);

        // randomized traffic with withdrawals and occasional reset
        rnd = 1;
        while (cyc < N - 64) begin
            for (int u = 0; u < 2; u++)
                for (int r = 0; r < 2; r++)
                    if (wt[u][r] - wh[u][r] < 4 && $urandom_range(0, 3) == 0)
                        push(u, r, $urandom_range(0, 15));
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            feed();
            tick();
        end
        running = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/piso_sched.md
# piso_sched

Two-requester scheduler and sequencer for the 4-bit parallel-in/serial-out shifter. Accepts parallel words from two independent sources over valid/ready handshakes, arbitrates round-robin, and drives the shifter's `sel`/`indata` pins through one load cycle and DW shift cycles per word. It also emits a per-bit strobe, source tag and last-bit flag aligned with the shifter's registered `outbit`, so downstream logic can frame the serial stream.

## Interface
- `DW`, 4: word width; equals the shifter's `indata` width.
- `GAP`, 0: idle cycles inserted after each word's last shift (0–15).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-low reset. The shifter instance gets `~rst`, because its reset is active-high.
- `req0_valid`  in  1  requester 0 has a word.
- `req0_data`  in  DW  requester 0 word; bit 0 is serialized first.
- `req0_ready`  out  1  scheduler accepts requester 0 this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as above, for requester 1.
- `sh_sel`  out  1  to shifter `sel`: 0 = load, 1 = shift.
- `sh_data`  out  DW  to shifter `indata`; registered.
- `bit_vld`  out  1  shifter `outbit` holds a valid serial bit this cycle.
- `bit_src`  out  1  source (0/1) of the current bit; meaningful only when `bit_vld` = 1.
- `frame_last`  out  1  current bit is the word's final (MSB) bit; only when `bit_vld` = 1.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States are IDLE, LOAD, SHIFT and GAP.
- **IDLE**
  - `req*_ready` is combinational. `reqN_ready` = (state == IDLE) & rst & reqN_valid & granted(N).
  - Grant rule: a sole valid requester wins. When both are valid, the winner is the one not served last.
  - `last_src` resets to 1, so requester 0 wins the first tie.
  - On a handshake (valid & ready):
    - latch the data into `sh_data`;
    - latch the source into `cur_src` and `last_src`;
    - clear the bit counter;
    - go to LOAD.
  - With no valid request, stay in IDLE.
- **LOAD** (1 cycle)
  - `sh_sel` = 0, so the shifter captures `sh_data` at the end of the cycle.
  - Go to SHIFT.
- **SHIFT** (DW cycles)
  - `sh_sel` = 1. The counter increments each cycle.
  - After the cycle with counter = DW−1: go to GAP if GAP > 0, else to IDLE.
- **GAP** (GAP cycles)
  - `sh_sel` = 0. The gap counter runs down, then the block returns to IDLE.
- **Selector outside SHIFT:** `sh_sel` = 0 in IDLE, LOAD and GAP. The shifter reloads the held `sh_data` harmlessly and never shifts.
- **Bit strobes**
  - `bit_vld`, `bit_src` and `frame_last` are registered copies of (state == SHIFT), `cur_src` and (counter == DW−1).
  - This delays them one cycle, matching the shifter's registered `outbit`.
- **Widths:**
  - bit counter: $clog2(DW) bits;
  - gap counter: 4 bits.
- **Ready while busy:** `req*_ready` is 0 in LOAD, SHIFT and GAP. Requesters hold valid and data until the handshake.
- **Reset value of every output** (after a clock edge with `rst` = 0):
  - state = IDLE;
  - `sh_sel` = 0 and `sh_data` = 0;
  - `bit_vld`, `bit_src`, `frame_last` = 0;
  - `busy` = 0;
  - `last_src` = 1;
  - `req*_ready` = 0 whenever `rst` = 0.
- **Reset mid-word:** the word in flight is abandoned. No further `bit_vld` pulses appear after the reset edge, and the requester is not re-offered the word.
- **Valid dropped before grant:** no transfer occurs and the round-robin state is unchanged.

## Timing
- Handshake at edge T (end of an IDLE cycle):
  - LOAD during cycle T+1;
  - SHIFT during T+2 … T+DW+1;
  - `bit_vld` high during T+3 … T+DW+2.
- Within a word, bit k (k = 0 = LSB) appears on `outbit` with `bit_vld` in cycle T+3+k. `frame_last` = 1 at k = DW−1.
- The earliest next handshake is at the end of cycle T+DW+2+GAP. Sustained throughput is one word per DW+2+GAP cycles; with DW=4 and GAP=0 that is one word every 6 cycles.
- `bit_vld` for the last bit coincides with the first IDLE cycle (GAP=0). The new word's LOAD does not disturb that bit.

## Test plan
- **Single word from requester 0.** Release reset; req0_valid=1 with req0_data=4'b1011 handshakes at T.
  - `bit_vld` high for T+3 … T+6, with `outbit` = 1, 1, 0, 1.
  - `bit_src` = 0 throughout; `frame_last` only at T+6.
  - `busy` high for T+1 … T+5.
- **Tie after reset.** Both valid, req0=4'h5 and req1=4'hA, held until accepted.
  - req0 is granted first, req1 second.
  - Serial bits are 1,0,1,0 then 0,1,0,1, with `bit_src` 0 then 1.
  - Handshakes are 6 cycles apart.
- **Back-to-back single source.** req1 streams 4'h1, 4'h2, 4'h3 with GAP=0.
  - Handshakes every 6 cycles; `bit_vld` shows a 4-on/2-off pattern.
  - `req1_ready` is never high while `busy`=1.
- **GAP=3.** Same stream as above.
  - Handshake spacing is 9 cycles, and `sh_sel`=0 during the gap.
- **Reset mid-shift.** Assert `rst`=0 in the second SHIFT cycle.
  - Next edge: `busy`=0, `sh_sel`=0, `sh_data`=0 and `bit_vld`=0.
  - No further `bit_vld` until a new handshake; the next tie goes to req0.
- **Valid withdrawn.** req1_valid pulses for 1 cycle during SHIFT and is then low.
  - No handshake, no serial output for req1, and `last_src` is unchanged.
